// File: rtl/prime_pkg.sv
// Shared definitions for the sequential prime checker: FSM encoding,
// first odd trial divisor and the overflow-free square comparison.
package prime_pkg;

  localparam int MAX_WIDTH = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_DIV   = 3'd2;
  localparam logic [2:0] ST_EVAL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CHECK = ST_CHECK,
    DIV   = ST_DIV,
    EVAL  = ST_EVAL,
    DONE  = ST_DONE
  } state_t;

  localparam int FIRST_ODD_DIV = 3;

  // True when d*d > n; the product is formed at double width so it cannot wrap.
  function automatic logic square_exceeds(input logic [MAX_WIDTH-1:0] d,
                                          input logic [MAX_WIDTH-1:0] n);
    logic [2*MAX_WIDTH-1:0] sq;
    sq = (2*MAX_WIDTH)'(d) * (2*MAX_WIDTH)'(d);
    return sq > (2*MAX_WIDTH)'(n);
  endfunction

endpackage

// File: rtl/serial_mod.sv
// Serial restoring remainder unit: one quotient bit per cycle, MSB first.
// rem holds dividend mod divisor in the cycle after done.
module serial_mod #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0]   part_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;

  // Partial remainder stays below divisor, so its shifted form fits WIDTH+1 bits.
  function automatic logic [WIDTH:0] step(input logic [WIDTH:0]   part,
                                          input logic             bit_in,
                                          input logic [WIDTH-1:0] dv);
    logic [WIDTH:0] trial;
    trial = {part[WIDTH-1:0], bit_in};
    if (trial >= {1'b0, dv}) trial = trial - {1'b0, dv};
    return trial;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      part_reg  <= '0;
      shift_reg <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else if (start) begin
      part_reg  <= step('0, dividend[WIDTH-1], divisor);
      shift_reg <= {dividend[WIDTH-2:0], 1'b0};
      cnt_reg   <= CW'(1);
      busy_reg  <= 1'b1;
    end else if (busy_reg) begin
      part_reg  <= step(part_reg, shift_reg[WIDTH-1], divisor);
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      cnt_reg   <= cnt_reg + CW'(1);
      if (cnt_reg == CW'(WIDTH-1)) busy_reg <= 1'b0;
    end
  end

  assign rem  = part_reg[WIDTH-1:0];
  assign done = busy_reg && (cnt_reg == CW'(WIDTH-1));

endmodule

// File: rtl/prime_checker_seq.sv
// Handshaked trial-division prime tester: checks 2, then odd divisors up to
// sqrt(n); reports the prime flag and the smallest nontrivial factor.
module prime_checker_seq
  import prime_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_prime,
  output logic [WIDTH-1:0] out_factor
);

  state_t           state;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] d_plus2;
  logic             start_reg;
  logic [WIDTH-1:0] rem;
  logic             div_done;

  assign d_plus2 = d_reg + WIDTH'(2);

  serial_mod #(.WIDTH(WIDTH)) u_mod (
    .clk      (clk),
    .reset    (reset),
    .start    (start_reg),
    .dividend (n_reg),
    .divisor  (d_reg),
    .rem      (rem),
    .done     (div_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      n_reg      <= '0;
      d_reg      <= '0;
      start_reg  <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_prime  <= 1'b0;
      out_factor <= '0;
    end else begin
      start_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_reg    <= in_data;
            in_ready <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (n_reg < WIDTH'(2)) begin
            out_prime  <= 1'b0;
            out_factor <= '0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (n_reg == WIDTH'(2) || n_reg == WIDTH'(3)) begin
            out_prime  <= 1'b1;
            out_factor <= '0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (!n_reg[0]) begin
            out_prime  <= 1'b0;
            out_factor <= WIDTH'(2);
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            d_reg <= WIDTH'(FIRST_ODD_DIV);
            if (square_exceeds(MAX_WIDTH'(FIRST_ODD_DIV), MAX_WIDTH'(n_reg))) begin
              out_prime  <= 1'b1;
              out_factor <= '0;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              start_reg <= 1'b1;
              state     <= DIV;
            end
          end
        end
        DIV: begin
          if (div_done) state <= EVAL;
        end
        EVAL: begin
          if (rem == '0) begin
            out_prime  <= 1'b0;
            out_factor <= d_reg;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            d_reg <= d_plus2;
            if (square_exceeds(MAX_WIDTH'(d_plus2), MAX_WIDTH'(n_reg))) begin
              out_prime  <= 1'b1;
              out_factor <= '0;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              start_reg <= 1'b1;
              state     <= DIV;
            end
          end
        end
        DONE: begin
          // Result is held untouched until the consumer takes it.
          if (out_ready) begin
            out_valid  <= 1'b0;
            out_prime  <= 1'b0;
            out_factor <= '0;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_checker_seq.sv
// Directed bench for prime_checker_seq at WIDTH=8: trivial cases, long
// divisor chains, reset abort, backpressure and a full operand sweep.
module tb_prime_checker_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_prime;
  logic [WIDTH-1:0] out_factor;

  int checks = 0;
  int errors = 0;

  prime_checker_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prime  (out_prime),
    .out_factor (out_factor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: least factor and number of odd divisors the algorithm tries.
  task automatic model(input int n, output int prime, output int factor, output int lat);
    int d;
    int dcount;
    prime  = 0;
    factor = 0;
    lat    = 1;
    if (n < 2) begin
      prime = 0;
    end else if (n == 2 || n == 3) begin
      prime = 1;
    end else if (n % 2 == 0) begin
      factor = 2;
    end else begin
      d      = 3;
      dcount = 0;
      prime  = 1;
      while (d * d <= n) begin
        dcount++;
        if (n % d == 0) begin
          prime  = 0;
          factor = d;
          break;
        end
        d += 2;
      end
      lat = 1 + dcount * (WIDTH + 1);
    end
  endtask

  // Called #1 after a rising edge. Accepts n, waits for the result, checks it,
  // and optionally completes the output handshake.
  task automatic run_op(input int n, input int exp_prime, input int exp_factor,
                        input int exp_lat, input bit ack);
    int lat;
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = WIDTH'(n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    check("out_valid_timeout", out_valid, 1);
    check("latency", lat, exp_lat);
    check("out_prime", out_prime, exp_prime);
    check("out_factor", out_factor, exp_factor);
    $display("n=%0d prime=%0d factor=%0d latency=%0d", n, out_prime, out_factor, lat);
    if (ack) begin
      @(posedge clk); #1;
      check("out_valid_after_ack", out_valid, 0);
      check("in_ready_after_ack", in_ready, 1);
    end
  endtask

  initial begin
    int p, f, l;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_prime", out_prime, 0);
    check("reset_out_factor", out_factor, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Abort in the middle of the divisor loop.
    in_valid = 1'b1;
    in_data  = 8'd251;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_in_ready_async", in_ready, 1);
    check("abort_out_valid_async", out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    $display("reset during DIV of n=251: in_ready=%0d out_valid=%0d", in_ready, out_valid);
    @(posedge clk); #1;
    check("abort_no_result", out_valid, 0);
    run_op(7, 1, 0, 1, 1);

    // Trivial operands back to back.
    run_op(0, 0, 0, 1, 1);
    run_op(1, 0, 0, 1, 1);
    run_op(2, 1, 0, 1, 1);
    run_op(3, 1, 0, 1, 1);
    run_op(4, 0, 2, 1, 1);

    // Long divisor chains.
    run_op(251, 1, 0, 64, 1);
    run_op(221, 0, 13, 55, 1);
    run_op(9, 0, 3, 10, 1);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    run_op(25, 0, 5, 19, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_out_factor", out_factor, 5);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    $display("backpressure n=25 released after 20 stalled cycles");

    // Every 8-bit operand against the reference model.
    for (int n = 0; n < 256; n++) begin
      model(n, p, f, l);
      run_op(n, p, f, l, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prime_checker_seq.md
Name: prime_checker_seq

Overview:
- Sequential, parametrised prime tester for WIDTH-bit unsigned operands.
- Accepts one operand through a valid/ready handshake.
- Runs trial division by 2, then by odd divisors up to sqrt(n), using a serial restoring remainder unit.
- Returns a prime flag plus the smallest nontrivial factor. It replaces the fixed 4-bit combinational prime detector wherever operands are wider than 4 bits or results are consumed by a handshaked datapath.

Parameters:
- WIDTH, 8, operand width in bits (legal range 4..16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand present on in_data.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  unsigned operand n.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_prime  output  1  1 = n is prime.
- out_factor  output  WIDTH  smallest factor >1 when n is composite; 0 when n is prime or n<2.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_prime=0, out_factor=0. Internal n, d and rem are cleared.
- Reset mid-operation: the operation is aborted and no result is produced.
- Accept: occurs on a rising edge where in_valid & in_ready. in_ready=1 only in IDLE. n is latched and the FSM moves to CHECK.
- CHECK (1 cycle):
  - n<2 -> DONE, prime=0, factor=0.
  - n==2 or n==3 -> DONE, prime=1, factor=0.
  - n even (n>=4) -> DONE, prime=0, factor=2.
  - otherwise d=3; if d*d>n -> DONE, prime=1 (covers n=5,7); else -> DIV.
- DIV (exactly WIDTH cycles):
  - sub-module computes rem = n mod d, one restoring step per cycle, MSB first.
  - d is held stable for the whole DIV phase.
- EVAL (1 cycle):
  - rem==0 -> DONE, prime=0, factor=d.
  - else d=d+2; if d*d>n -> DONE, prime=1, factor=0; else -> DIV.
- Arithmetic widths:
  - d*d is computed at 2*WIDTH bits, so the comparison never overflows.
  - d is held at WIDTH bits. d cannot wrap, because the loop exits once d*d>n, before d exceeds 2^(WIDTH/2)+2.
- Latency: let D = number of divisors actually tested in DIV. out_valid rises after rising edge k+1+D*(WIDTH+1), where k is the accept edge. Trivial cases have D=0, giving latency 1.
- DONE:
  - out_valid=1; out_prime and out_factor are stable while out_valid=1.
  - on an edge with out_ready=1 -> IDLE: out_valid drops and in_ready rises in the next cycle.
  - there is no same-cycle result/accept bypass.
  - out_ready is ignored outside DONE; in_valid is ignored outside IDLE.
- Continuous backpressure: a block held in DONE indefinitely keeps its result unchanged.

Decomposition:
- Shared package (prime_pkg):
  - FSM state encoding: IDLE, CHECK, DIV, EVAL, DONE (3-bit localparams).
  - constant FIRST_ODD_DIV=3.
  - function for the 2*WIDTH-bit square comparison.
- Sub-module serial_mod (parameter WIDTH):
  - inputs: start, dividend, divisor.
  - outputs: rem, done.
  - done pulses on the WIDTH-th cycle after start.
  - restoring algorithm with a WIDTH+1-bit partial remainder.
- Top level: holds the FSM, the d register and the handshake logic.

Test Plan (WIDTH=8):
- Reset mid-DIV with n=251 accepted -> next cycle: in_ready=1, out_valid=0; then apply n=7 -> prime=1, factor=0, latency 1.
- n=0, 1, 2, 3, 4 back-to-back with out_ready=1 -> (prime,factor) = (0,0), (0,0), (1,0), (1,0), (0,2); each out_valid appears 1 edge after its accept.
- n=251 -> prime=1, factor=0. Seven divisors (3..15) tested, so out_valid appears 64 edges after accept.
- n=221 (13*17) -> prime=0, factor=13. Six divisors tested, so latency 55. n=9 -> prime=0, factor=3, latency 10.
- Backpressure: n=25 with out_ready=0 for 20 cycles -> out_valid stays 1, factor=5 stable, in_ready=0. Raising out_ready gives one handshake, then in_ready=1 on the next cycle.
- Sweep all 256 operands against a software prime/least-factor model -> all out_prime and out_factor values match.
